// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seg7_scan_controller_decoder.sv
// Hex nibble to 7-segment glyph lookup, bit order y[6]=a .. y[0]=g, active-high.
module decoder_7seg_table
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0: seg = 7'b1111110;
                4'h1: seg = 7'b0110000;
                4'h2: seg = 7'b1101101;
                4'h3: seg = 7'b1111001;
                4'h4: seg = 7'b0110011;
                4'h5: seg = 7'b1011011;
                4'h6: seg = 7'b1011111;
                4'h7: seg = 7'b1110000;
                4'h8: seg = 7'b1111111;
                4'h9: seg = 7'b1111011;
                4'hA: seg = 7'b1110111;
                4'hB: seg = 7'b0011111;
                4'hC: seg = 7'b1001110;
                4'hD: seg = 7'b0111101;
                4'hE: seg = 7'b1001111;
                default: seg = 7'b1000111;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display with tear-free updates.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    update_req,
    output logic                    update_ack,
    output seg_t                    seg_y,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(max_int(SCAN_DIV, BLANK_CYCLES) + 1);
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state, state_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [4*NUM_DIGITS-1:0] active, pend_buf;
    logic                    pend_flag;
    logic                    applied_r, wrap_r;
    logic                    step, wrap, frame_entry;
    logic [3:0]              nibble;
    logic                    lead_blank;
    seg_t                    dec_seg;

    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) nibble = active[4*i +: 4];
        end
    end

`ifdef SEG7_LZB_EN
    logic [IDX_W-1:0] msd;

    // Digit 0 is never blanked, so msd starts at 0 even when active is all zero.
    always_comb begin
        msd = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (active[4*i +: 4] != 4'h0) msd = IDX_W'(i);
        end
    end

    assign lead_blank = (idx > msd);
`else
    assign lead_blank = 1'b0;
`endif

    decoder_7seg_table u_decoder (
        .nibble (nibble),
        .blank  (lead_blank),
        .seg    (dec_seg)
    );

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        cnt_nx      = cnt;
        step        = 1'b0;
        wrap        = 1'b0;
        frame_entry = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx    = SHOW;
                    idx_nx      = '0;
                    cnt_nx      = '0;
                    frame_entry = 1'b1;
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt_nx = '0;
                        if (BLANK_CYCLES == 0) step = 1'b1;
                        else state_nx = BLANK;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt_nx = '0;
                        step   = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
            if (step) begin
                state_nx = SHOW;
                if (idx == IDX_LAST) begin
                    idx_nx      = '0;
                    wrap        = 1'b1;
                    frame_entry = 1'b1;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
        end
    end

    // Pulses are delayed one stage so they line up with the registered display outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            active     <= '0;
            pend_buf   <= '0;
            pend_flag  <= 1'b0;
            applied_r  <= 1'b0;
            wrap_r     <= 1'b0;
            update_ack <= 1'b0;
            frame_done <= 1'b0;
            seg_y      <= SEG_BLANK;
            digit_en   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
            if (frame_entry && pend_flag) begin
                active    <= pend_buf;
                pend_flag <= update_req;
            end else if (update_req) begin
                pend_flag <= 1'b1;
            end
            if (update_req) pend_buf <= value;
            applied_r  <= frame_entry && pend_flag;
            wrap_r     <= wrap;
            update_ack <= applied_r;
            frame_done <= wrap_r;
            if (state == SHOW && enable) begin
                seg_y    <= dec_seg;
                digit_en <= NUM_DIGITS'(1) << idx;
            end else begin
                seg_y    <= SEG_BLANK;
                digit_en <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Randomized self-checking bench for seg7_scan_controller against a frame-position reference model.
module tb_seg7_scan_controller;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = ND * SLOT;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        update_req = 1'b0;
    logic [15:0] value = '0;
    logic        update_ack;
    logic        frame_done;
    logic [6:0]  seg_y;
    logic [3:0]  digit_en;

    int cmpCount = 0;
    int errCount = 0;

    // Reference model: position within the frame since scanning started (-1 = dark).
    int          tM = -1;
    logic [15:0] activeM = '0;
    logic [15:0] pendM = '0;
    bit          flagM = 1'b0;
    bit          appliedM = 1'b0;
    bit          wrapM = 1'b0;
    bit          lastLit = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_controller #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .value      (value),
        .update_req (update_req),
        .update_ack (update_ack),
        .seg_y      (seg_y),
        .digit_en   (digit_en),
        .frame_done (frame_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmpCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] glyphOf(input logic [15:0] act, input int d);
`ifdef SEG7_LZB_EN
        int msd = 0;
        for (int i = 1; i < ND; i++) begin
            if (act[4*i +: 4] != 4'h0) msd = i;
        end
        if (d > msd) return 7'b0;
`endif
        return GLYPH[act[4*d +: 4]];
    endfunction

    task automatic modelEdge();
        bit boundary;
        boundary = 1'b0;
        appliedM = 1'b0;
        wrapM    = 1'b0;
        if (!enable) begin
            tM = -1;
        end else if (tM < 0) begin
            tM = 0;
            boundary = 1'b1;
        end else begin
            tM = (tM + 1) % FRAME;
            if (tM == 0) begin
                boundary = 1'b1;
                wrapM = 1'b1;
            end
        end
        if (boundary && flagM) begin
            activeM  = pendM;
            flagM    = update_req;
            appliedM = 1'b1;
        end else if (update_req) begin
            flagM = 1'b1;
        end
        if (update_req) pendM = value;
    endtask

    task automatic cycle();
        bit         lit;
        int         d;
        logic [6:0] eSeg;
        logic [3:0] eEn;
        logic       eAck, eFd;
        lit  = enable && (tM >= 0) && ((tM % SLOT) < SD);
        d    = lit ? (tM / SLOT) : 0;
        eEn  = lit ? 4'(1 << d) : 4'b0;
        eSeg = lit ? glyphOf(activeM, d) : 7'b0;
        eAck = appliedM;
        eFd  = wrapM;
        @(posedge clk);
        #1;
        checkOutput("seg_y", 32'(seg_y), 32'(eSeg));
        checkOutput("digit_en", 32'(digit_en), 32'(eEn));
        checkOutput("update_ack", 32'(update_ack), 32'(eAck));
        checkOutput("frame_done", 32'(frame_done), 32'(eFd));
        lastLit = lit;
        modelEdge();
    endtask

    task automatic applyStimulus(input bit en, input bit req, input logic [15:0] val, input int n);
        enable     = en;
        update_req = req;
        value      = val;
        for (int i = 0; i < n; i++) begin
            cycle();
            update_req = 1'b0;
        end
    endtask

    task automatic checkDark(input string tag);
        checkOutput({tag, "_seg"}, 32'(seg_y), 32'h0);
        checkOutput({tag, "_en"}, 32'(digit_en), 32'h0);
        checkOutput({tag, "_ack"}, 32'(update_ack), 32'h0);
        checkOutput({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    initial begin
        logic [15:0] mask;
        int          guard;
        #22;
        checkDark("reset");
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 20);

        applyStimulus(1'b0, 1'b1, 16'h1234, 1);
        applyStimulus(1'b1, 1'b0, 16'h1234, 47);

        applyStimulus(1'b1, 1'b1, 16'hABCD, 1);
        applyStimulus(1'b1, 1'b0, 16'hABCD, 45);

        applyStimulus(1'b1, 1'b1, 16'h0001, 1);
        applyStimulus(1'b1, 1'b0, 16'h0001, 3);
        applyStimulus(1'b1, 1'b1, 16'h00F0, 1);
        applyStimulus(1'b1, 1'b0, 16'h00F0, 45);

        applyStimulus(1'b1, 1'b1, 16'h0070, 1);
        applyStimulus(1'b1, 1'b0, 16'h0070, 42);
        applyStimulus(1'b1, 1'b1, 16'h0000, 1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 42);

        applyStimulus(1'b0, 1'b1, 16'h9E8F, 3);
        applyStimulus(1'b1, 1'b0, 16'h9E8F, 30);

        // Pending update queued just before an asynchronous reset must be lost.
        applyStimulus(1'b1, 1'b1, 16'h5678, 1);
        guard = 0;
        while (!lastLit && guard < 10) begin
            cycle();
            guard++;
        end
        checkOutput("pre_reset_lit", 32'(lastLit), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkDark("mid_reset");
        tM = -1; activeM = '0; pendM = '0; flagM = 1'b0; appliedM = 1'b0; wrapM = 1'b0;
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0000, 25);

        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(59) == 0) enable = ~enable;
            case ($urandom_range(4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            applyStimulus(enable, ($urandom_range(11) == 0), 16'($urandom) & mask, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexed scan controller for a common-segment, multi-digit 7-segment display. It holds a NUM_DIGITS-wide hexadecimal value and drives one digit at a time, with dead-time between digits to suppress ghosting. New values are applied only at frame boundaries, so the display never tears. It sits between the value-producing logic (counters, registers) and the board pins; the single glyph decoder is shared across all digits.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- SCAN_DIV, 50000, clk cycles each digit is lit per slot (>= 2)
- BLANK_CYCLES, 500, dead-time cycles after each digit, all outputs off (0 = no dead-time)
- clk  input  1  system clock; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = scanning; 0 = display dark
- value  input  4*NUM_DIGITS  nibble i is the value of digit i (digit 0 = least significant)
- update_req  input  1  single-cycle strobe: capture `value` into the pending buffer
- update_ack  output  1  one-cycle pulse when the pending value becomes the displayed value
- seg_y  output  7  segment pattern, active-high, bit order y[6]=a … y[0]=g
- digit_en  output  NUM_DIGITS  one-hot digit enable, active-high; all-zero when dark
- frame_done  output  1  one-cycle pulse at the end of the last digit's slot

## Operation
- States:
  - IDLE: dark.
  - SHOW: digit idx lit, counting SCAN_DIV.
  - BLANK: dark, counting BLANK_CYCLES.
- IDLE→SHOW(idx=0) when enable=1. SHOW→BLANK after SCAN_DIV cycles, or SHOW→SHOW(idx+1) directly if BLANK_CYCLES=0. BLANK→SHOW(idx+1) after BLANK_CYCLES cycles.
- idx wraps NUM_DIGITS-1→0. Any state→IDLE when enable=0; this clears idx and the counter.
- Pending buffer: update_req=1 writes `value` and sets the pending flag. A repeated req before apply overwrites the buffer (latest wins; one ack only).
- Frame boundary = entry to SHOW idx=0, from IDLE or by wrap. If pending is set at that edge: active ← pending, clear the flag, pulse update_ack.
- A req in the same cycle as the boundary is applied at the next boundary.
- frame_done pulses on the wrap edge only. It does not pulse on IDLE entry/exit.
- In SHOW: seg_y = decode(active nibble idx), digit_en = 1<<idx. In IDLE/BLANK: both outputs are 0.
- Active/pending registers are unaffected by enable; the display resumes with the latest active value.

## Timing
- Reset (async assert): every output is 0. State IDLE, idx=0, counter=0, active=0, pending=0, flag=0.
- Outputs are registered. seg_y/digit_en reflect the state one cycle after the state register changes; update_ack and frame_done are registered alongside.
- Enable rise at edge N: digit 0 is visible from edge N+1. Enable fall: dark on the following edge.
- Slot length is exactly SCAN_DIV lit cycles + BLANK_CYCLES dark cycles. Frame = NUM_DIGITS×(SCAN_DIV+BLANK_CYCLES) cycles.
- Reset mid-frame: outputs go dark immediately (asynchronously) and the pending update is lost.
- Counter width = $clog2(max(SCAN_DIV,BLANK_CYCLES)+1). idx width = $clog2(NUM_DIGITS), minimum 1.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking is enabled.
  - Digits above the highest nonzero nibble of `active` show seg_y=0, while digit_en stays asserted and timing is unchanged.
  - Digit 0 is always shown, so active=0 displays a single "0".
- SEG7_LZB_EN undefined: every digit shows its glyph, including leading zeros.

## Structure
- Package seg7_pkg holds:
  - seg_t (logic[6:0])
  - SEG_BLANK = 0
  - scan_state_t enum {IDLE, SHOW, BLANK}
- One sub-module: a decoder_7seg_table instance, fed by the nibble mux on idx.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1.
- Reset, enable=0 for 20 cycles -> seg_y=0, digit_en=0, no pulses.
- value=16'h1234, req, enable=1 -> first frame: digit_en 0001/0010/0100/1000 for 4 cycles each with 1 dark cycle between. seg_y=0110011, 1111001, 1101101, 0110000. update_ack at the first boundary. frame_done every 20 cycles.
- Mid-frame req 16'hABCD -> current frame still shows 1234; ack and the new glyphs (0111101 on digit 0) start at the next boundary.
- Two reqs (16'h0001 then 16'h00F0) in one frame -> single ack; 00F0 is displayed.
- SEG7_LZB_EN, value=16'h0070 -> digits 3 and 2 show 0, digit 1 shows 1110000, digit 0 shows 1111110. With value=0, only digit 0 shows 1111110.
- reset_n low mid-SHOW -> outputs 0 in the same cycle. After release with enable=1 -> scan restarts at digit 0 showing the reset value 0 (1111110).
